hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, memory wait-cycle limit before error (range 1..15).
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Rs1D, Rs2D  input  5 each  source registers of instruction in Decode.
REQ-005 Rs1E, Rs2E, RdE  input  5 each  source/destination registers in Execute.
REQ-006 RdM, RdW  input  5 each  destination registers in Memory/Writeback.
REQ-007 RegWriteM, RegWriteW  input  1 each  register-write valid in Memory/Writeback.
REQ-008 LoadE  input  1  instruction in Execute is a load.
REQ-009 PCSrcE  input  1  taken branch/jump resolved in Execute.
REQ-010 MemReqM, MemReadyM  input  1 each  data-memory request in Memory / memory ready acknowledge.
REQ-011 ForwardAE, ForwardBE  output  2 each  ALU operand bypass select.
REQ-012 StallF, StallD, StallE, StallM  output  1 each  hold Fetch/Decode/Execute/Memory pipeline registers.
REQ-013 FlushD, FlushE, FlushW  output  1 each  clear Decode/Execute/Writeback pipeline registers next edge.
REQ-014 MemErr  output  1  sticky memory-timeout error.
REQ-015 StallCnt  output  16  saturating count of cycles with StallF=1.

Function
REQ-016 Forwarding SHALL be combinational: ForwardAE=10 when Rs1E!=0, Rs1E==RdM, RegWriteM; else 01 when Rs1E!=0, Rs1E==RdW, RegWriteW; else 00 (M priority over W); ForwardBE identical using Rs2E.
REQ-017 Load-use hazard lwStall SHALL equal LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
REQ-018 memWait SHALL equal MemReqM & ~MemReadyM in states RUN or WAIT.
REQ-019 Priority SHALL be: ERROR > memWait > PCSrcE > lwStall > none.
REQ-020 ERROR or memWait: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; PCSrcE/lwStall ignored that cycle and re-evaluated after release.
REQ-021 PCSrcE (no memWait): FlushD=FlushE=1, all stalls 0.
REQ-022 lwStall only: StallF=StallD=1, FlushE=1, others 0; exactly one bubble per load-use pair.
REQ-023 FSM states RUN, WAIT, ERROR: RUN->WAIT on memWait; WAIT->RUN when MemReadyM=1; WAIT->ERROR when wait counter reaches MEM_TIMEOUT with MemReadyM=0; ERROR held until reset.
REQ-024 Wait counter (4 bits) SHALL clear in RUN, increment each WAIT cycle, value 1 on the first WAIT cycle; MemReadyM on the same cycle as counter==MEM_TIMEOUT SHALL return to RUN (ready wins).
REQ-025 MemErr SHALL be 1 exactly while in ERROR.
REQ-026 StallCnt SHALL increment each cycle StallF=1 and saturate at 16'hFFFF.

Reset
REQ-027 On reset=1 at a rising edge: state=RUN, wait counter=0, StallCnt=0, MemErr=0.
REQ-028 While reset=1 all Stall* and Flush* outputs SHALL be 0 except FlushD=FlushE=FlushW=1; ForwardAE/BE=00.
REQ-029 Reset mid-WAIT or in ERROR SHALL abandon the access with no residual stall on the first cycle after reset.

Structure
REQ-030 Package riscv_pipe_pkg SHALL hold fwd_sel_t (FWD_NONE=00, FWD_WB=01, FWD_MEM=10) and hz_state_t (RUN, WAIT, ERROR).
REQ-031 Sub-module fwd_sel (one-operand forwarding compare) SHALL be instantiated twice, for A and B.
REQ-032 FSM and counters SHALL be the only state; all hazard outputs are combinational from state and inputs.

Verification
REQ-033 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; Rs1E=0 with the same -> 00.
REQ-034 LoadE=1, RdE=7, Rs2D=7 -> one cycle StallF=StallD=FlushE=1; next cycle with load advanced -> all 0; StallCnt=1.
REQ-035 PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=0.
REQ-036 MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> 3 cycles all stalls + FlushW, RUN on cycle 4, MemErr=0.
REQ-037 MemReadyM held 0 for MEM_TIMEOUT+1 cycles -> ERROR, MemErr=1, stalls held; reset -> MemErr=0, state RUN, StallCnt=0.
REQ-038 Force 70000 stall cycles -> StallCnt=16'hFFFF and stays there.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the pipeline hazard unit: bypass selects and the
// memory-wait state machine encoding.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    WAIT  = 2'b01,
    ERROR = 2'b10
  } hz_state_t;

  localparam int REG_W  = 5;
  localparam int WCNT_W = 4;
  localparam int SCNT_W = 16;

endpackage

// File: rtl/fwd_sel.sv
// Bypass select for one ALU operand: Memory-stage result wins over Writeback,
// and register x0 is never forwarded.
module fwd_sel
  import riscv_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rdm,
  input  logic [REG_W-1:0] rdw,
  input  logic             regwritem,
  input  logic             regwritew,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_NONE;
    if (rs != '0 && rs == rdm && regwritem)
      sel = FWD_MEM;
    else if (rs != '0 && rs == rdw && regwritew)
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/memory-wait
// stall and flush control, memory timeout FSM and a saturating stall counter.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  Rs1D,
  input  logic [REG_W-1:0]  Rs2D,
  input  logic [REG_W-1:0]  Rs1E,
  input  logic [REG_W-1:0]  Rs2E,
  input  logic [REG_W-1:0]  RdE,
  input  logic [REG_W-1:0]  RdM,
  input  logic [REG_W-1:0]  RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [SCNT_W-1:0] StallCnt
);

  localparam logic [WCNT_W-1:0] TIMEOUT = WCNT_W'(MEM_TIMEOUT);

  hz_state_t         state;
  logic [WCNT_W-1:0] wcnt;
  fwd_sel_t          sel_a, sel_b;
  logic              lw_stall, mem_wait;

  fwd_sel u_fwd_a (
    .rs(Rs1E), .rdm(RdM), .rdw(RdW),
    .regwritem(RegWriteM), .regwritew(RegWriteW), .sel(sel_a)
  );

  fwd_sel u_fwd_b (
    .rs(Rs2E), .rdm(RdM), .rdw(RdW),
    .regwritem(RegWriteM), .regwritew(RegWriteW), .sel(sel_b)
  );

  assign lw_stall = LoadE && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);
  assign mem_wait = (state == RUN || state == WAIT) && MemReqM && !MemReadyM;
  assign MemErr   = (state == ERROR);

  assign ForwardAE = reset ? FWD_NONE : sel_a;
  assign ForwardBE = reset ? FWD_NONE : sel_b;

  // Reset flushes D/E/W; otherwise ERROR/memory wait freezes everything
  // and squashes the write-back, ahead of branch flush and load-use bubble.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (state == ERROR || mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Wait counter reads 1 on the first WAIT cycle; ready on the timeout
  // cycle still returns to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wcnt     <= '0;
      StallCnt <= '0;
    end else begin
      if (StallF && StallCnt != '1)
        StallCnt <= StallCnt + SCNT_W'(1);
      case (state)
        RUN: begin
          wcnt <= '0;
          if (mem_wait) begin
            state <= WAIT;
            wcnt  <= WCNT_W'(1);
          end
        end
        WAIT: begin
          if (MemReadyM) begin
            state <= RUN;
            wcnt  <= '0;
          end else if (wcnt == TIMEOUT) begin
            state <= ERROR;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the combinational
// forwarding/priority logic plus hand sequences for the memory-wait FSM.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [15:0] StallCnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCnt(StallCnt)
  );

  // {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
  logic [11:0] outv;
  assign outv = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                 FlushD, FlushE, FlushW, MemErr};

  localparam logic [11:0] EXP_ZERO = 12'b0000_0000_0000;
  localparam logic [11:0] EXP_LW   = 12'b0000_1100_0100;
  localparam logic [11:0] EXP_BR   = 12'b0000_0000_1100;
  localparam logic [11:0] EXP_MEM  = 12'b0000_1111_0010;
  localparam logic [11:0] EXP_ERR  = 12'b0000_1111_0011;
  localparam logic [11:0] EXP_RST  = 12'b0000_0000_1110;

  typedef struct {
    string      nm;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, lde, pcs;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[11];

  int nvec  = 0;
  int nfail = 0;
  logic [15:0] model_cnt  = 16'd0;
  logic        cur_stallf = 1'b0;

  task automatic chk(input string nm, input logic [11:0] exp);
    #1;
    nvec++;
    cur_stallf = exp[7];
    if (outv !== exp) begin
      nfail++;
      $display("FAIL %s: outputs got %b want %b", nm, outv, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] exp);
    #1;
    nvec++;
    if (StallCnt !== exp) begin
      nfail++;
      $display("FAIL %s: StallCnt got %h want %h", nm, StallCnt, exp);
    end
  endtask

  // Advance one clock; the reference stall count follows the expected StallF.
  task automatic step();
    @(posedge clk);
    if (reset) model_cnt = 16'd0;
    else if (cur_stallf && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    #2;
  endtask

  task automatic clr();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    LoadE = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic set_lw();
    clr();
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  initial begin
    tbl[0]  = '{"fwd_a_mem",    5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 12'b1000_0000_0000};
    tbl[1]  = '{"fwd_a_x0",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, EXP_ZERO};
    tbl[2]  = '{"fwd_a_wb_b_m", 5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 12'b0110_0000_0000};
    tbl[3]  = '{"fwd_m_nowr",   5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 12'b0101_0000_0000};
    tbl[4]  = '{"fwd_none",     5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, EXP_ZERO};
    tbl[5]  = '{"lw_rs2",       5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EXP_LW};
    tbl[6]  = '{"lw_rd_x0",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EXP_ZERO};
    tbl[7]  = '{"no_load",      5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_ZERO};
    tbl[8]  = '{"br_over_lw",   5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, EXP_BR};
    tbl[9]  = '{"lw_rs1",       5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EXP_LW};
    tbl[10] = '{"br_with_fwd",  5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 12'b1000_0000_1100};

    // Reset: outputs forced even with hazards present on the inputs
    reset = 1'b1;
    set_lw();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    step();
    step();
    chk("reset_outs", EXP_RST);
    chk16("reset_cnt", 16'd0);
    reset = 1'b0;
    clr();
    step();

    // Single load-use bubble
    set_lw();
    chk("lw_bubble", EXP_LW);
    step();
    clr();
    chk("lw_release", EXP_ZERO);
    chk16("lw_cnt", model_cnt);
    step();

    for (int i = 0; i < 11; i++) begin
      Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e;
      Rs2E = tbl[i].rs2e; RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
      RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww;
      LoadE = tbl[i].lde; PCSrcE = tbl[i].pcs;
      MemReqM = 1'b0; MemReadyM = 1'b0;
      chk(tbl[i].nm, tbl[i].exp);
      step();
    end
    clr();
    chk("table_idle", EXP_ZERO);
    step();

    // Three wait cycles with a branch pending: branch acts only after release
    for (int c = 1; c <= 4; c++) begin
      clr();
      MemReqM = 1'b1; MemReadyM = (c == 4); PCSrcE = 1'b1;
      chk((c == 4) ? "mem_release_br" : "mem_wait", (c == 4) ? EXP_BR : EXP_MEM);
      step();
    end
    clr();
    chk("mem_back_run", EXP_ZERO);
    chk16("mem_cnt", model_cnt);
    step();

    // Ready on the cycle the wait counter hits the limit: back to RUN
    for (int c = 1; c <= 16; c++) begin
      clr();
      MemReqM = 1'b1; MemReadyM = (c == 16);
      chk((c == 16) ? "ready_at_limit" : "limit_wait", (c == 16) ? EXP_ZERO : EXP_MEM);
      step();
    end
    clr();
    chk("limit_no_err", EXP_ZERO);
    step();
    chk("limit_no_err2", EXP_ZERO);
    step();

    // Timeout into ERROR
    for (int c = 1; c <= 16; c++) begin
      clr();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      chk("timeout_wait", EXP_MEM);
      step();
    end
    clr();
    MemReadyM = 1'b1; PCSrcE = 1'b1;
    chk("error_state", EXP_ERR);
    step();
    clr();
    chk("error_held", EXP_ERR);
    chk16("error_cnt", model_cnt);
    step();
    reset = 1'b1;
    cur_stallf = 1'b0;
    step();
    chk("error_reset", EXP_RST);
    chk16("error_reset_cnt", 16'd0);
    reset = 1'b0;
    MemReqM = 1'b1; MemReadyM = 1'b1;
    chk("after_err_reset", EXP_ZERO);
    step();

    // Reset in the middle of a wait leaves no stall behind
    for (int c = 1; c <= 3; c++) begin
      clr();
      MemReqM = 1'b1;
      chk("midwait", EXP_MEM);
      step();
    end
    reset = 1'b1;
    clr();
    chk("midwait_reset", EXP_RST);
    step();
    reset = 1'b0;
    chk("midwait_after", EXP_ZERO);
    step();

    // Saturation of the stall counter
    set_lw();
    chk("sat_lw", EXP_LW);
    for (int c = 0; c < 70000; c++) step();
    chk16("sat_cnt", 16'hFFFF);
    step();
    step();
    chk16("sat_hold", 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
